mem_crc_scrub_ctrl: RTL and testbench

Controller in front of the CRC-protected register-file memory (depth 2^ADDR_W, codeword = {data, crc4}).
- Encodes host writes and checks host reads.
- Arbitrates a single memory port between the host and a background scrubber.
- The scrubber walks all addresses periodically, detects CRC errors, and writes back corrected words.
- Sits between the bus-side requester and the memory array; the array has a combinational read, so mem_rdata is valid in the same cycle as mem_raddr.

---
 rtl/mem_crc_scrub_ctrl_if.sv | 36 +++
 rtl/mem_crc_scrub_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_crc_scrub_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_crc_scrub_ctrl_if.sv
// Host request/response and memory-port signals for mem_crc_scrub_ctrl.
// slave = controller side, master = requester/array side.
interface mem_crc_scrub_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  localparam int CODE_W = DATA_W + 4;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_err;
  logic              host_corr;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CODE_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [CODE_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output host_ready, host_rvalid, host_rdata, host_err, host_corr,
    output mem_wr_en, mem_waddr, mem_wdata, mem_raddr
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  host_ready, host_rvalid, host_rdata, host_err, host_corr,
    input  mem_wr_en, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/mem_crc_scrub_ctrl.sv
// CRC-4 protected memory controller: host write encode / read check, plus a periodic background scrubber.
// Host reads return 2 cycles after acceptance; CRC_CORRECT_EN adds single-bit correction (default: detect-only).
module mem_crc_scrub_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 8,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scrub_en,
  mem_crc_scrub_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     corr_cnt
);

  localparam int CODE_W = DATA_W + 4;
  localparam int TMR_W  = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    SCRUB_RD,
    SCRUB_WB
  } state_t;

  // LFSR form of data * x^4 mod (x^4 + x + 1), MSB first, init 0
  function automatic logic [3:0] crc4(input logic [DATA_W-1:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return c;
  endfunction

`ifdef CRC_CORRECT_EN
  // Codeword bit j (crc in [3:0]) flips the syndrome by x^j mod P
  function automatic logic [CODE_W-1:0] err_mask(input logic [3:0] syn);
    logic [3:0]        p;
    logic [CODE_W-1:0] m;
    p = 4'h1;
    m = '0;
    for (int j = 0; j < CODE_W; j++) begin
      if (syn == p) m[j] = 1'b1;
      p = {p[2:0], 1'b0} ^ (p[3] ? 4'h3 : 4'h0);
    end
    return m;
  endfunction
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   scrub_ptr_q, scrub_ptr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pending_q, pending_d;
  logic                host_ready_q, host_ready_d;
  logic                host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                host_err_q, host_err_d;
  logic                host_corr_q, host_corr_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [CODE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   mem_raddr_q, mem_raddr_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    corr_cnt_q, corr_cnt_d;

  logic [DATA_W-1:0]   rd_data;
  logic [3:0]          rd_crc;
  logic [3:0]          syn;
  logic                syn_nz;
  logic [CODE_W-1:0]   fix_mask;
  logic [CODE_W-1:0]   fixed_cw;
  logic                correctable;
  logic                expire;

  always_comb begin
    rd_data  = bus.mem_rdata[CODE_W-1:4];
    rd_crc   = bus.mem_rdata[3:0];
    syn      = crc4(rd_data) ^ rd_crc;
    syn_nz   = (syn != 4'h0);
`ifdef CRC_CORRECT_EN
    fix_mask = err_mask(syn);
`else
    fix_mask = '0;
`endif
    fixed_cw    = bus.mem_rdata ^ fix_mask;
    correctable = |fix_mask;
  end

  always_comb begin
    state_d       = state_q;
    scrub_ptr_d   = scrub_ptr_q;
    timer_d       = timer_q;
    pending_d     = pending_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_err_d    = host_err_q;
    host_corr_d   = host_corr_q;
    mem_wr_en_d   = 1'b0;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_raddr_d   = mem_raddr_q;
    err_cnt_d     = err_cnt_q;
    corr_cnt_d    = corr_cnt_q;
    expire        = 1'b0;

    if (scrub_en) begin
      if (timer_q == TMR_W'(SCRUB_INTERVAL - 1)) begin
        timer_d = '0;
        expire  = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    // An expiry landing while a scrub is still owed is simply dropped
    if (state_q == SCRUB_RD) pending_d = 1'b0;
    else if (expire)         pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.host_req) begin
          if (bus.host_we) begin
            state_d     = WRITE;
            mem_wr_en_d = 1'b1;
            mem_waddr_d = bus.host_addr;
            mem_wdata_d = {bus.host_wdata, crc4(bus.host_wdata)};
          end else begin
            state_d     = READ;
            mem_raddr_d = bus.host_addr;
          end
        end else if (pending_q) begin
          state_d     = SCRUB_RD;
          mem_raddr_d = scrub_ptr_q;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        host_rvalid_d = 1'b1;
        host_rdata_d  = fixed_cw[CODE_W-1:4];
        host_err_d    = syn_nz;
        host_corr_d   = correctable;
        if (syn_nz && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      SCRUB_RD: begin
        if (syn_nz && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (syn_nz && correctable) begin
          state_d     = SCRUB_WB;
          mem_wr_en_d = 1'b1;
          mem_waddr_d = scrub_ptr_q;
          mem_wdata_d = fixed_cw;
        end else begin
          scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
          state_d     = IDLE;
        end
      end
      SCRUB_WB: begin
        if (corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
        scrub_ptr_d = scrub_ptr_q + ADDR_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    host_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      scrub_ptr_q   <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      host_ready_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_err_q    <= 1'b0;
      host_corr_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      mem_raddr_q   <= '0;
      err_cnt_q     <= '0;
      corr_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      scrub_ptr_q   <= scrub_ptr_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      host_ready_q  <= host_ready_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_err_q    <= host_err_d;
      host_corr_q   <= host_corr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_raddr_q   <= mem_raddr_d;
      err_cnt_q     <= err_cnt_d;
      corr_cnt_q    <= corr_cnt_d;
    end
  end

  assign bus.host_ready  = host_ready_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_err    = host_err_q;
  assign bus.host_corr   = host_corr_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_raddr   = mem_raddr_q;
  assign err_cnt         = err_cnt_q;
  assign corr_cnt        = corr_cnt_q;

endmodule

// File: tb/tb_mem_crc_scrub_ctrl.sv
// Directed bench for mem_crc_scrub_ctrl with a 16-entry combinational-read array model.
// Expectations follow the build: CRC_CORRECT_EN selects the correcting results.
module tb_mem_crc_scrub_ctrl;

`ifdef CRC_CORRECT_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       scrub_en;
  logic [7:0] err_cnt;
  logic [7:0] corr_cnt;

  mem_crc_scrub_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  mem_crc_scrub_ctrl #(
    .ADDR_W(4), .DATA_W(8), .SCRUB_INTERVAL(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en), .bus(bus),
    .err_cnt(err_cnt), .corr_cnt(corr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] mem [16];
  logic        pl_vld;
  logic        pl_all;
  logic [3:0]  pl_addr;
  logic [11:0] pl_dat;
  int          wr_total;
  logic [3:0]  last_wa;
  logic [11:0] last_wd;

  assign bus.mem_rdata = mem[bus.mem_raddr];

  // Array model; bench preloads take effect on the same edge, after any DUT write
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_waddr] = bus.mem_wdata;
      wr_total = wr_total + 1;
      last_wa  = bus.mem_waddr;
      last_wd  = bus.mem_wdata;
    end
    if (pl_vld) begin
      if (pl_all) for (int k = 0; k < 16; k++) mem[k] = pl_dat;
      else        mem[pl_addr] = pl_dat;
    end
  end

  int n_chk;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input bit all, input logic [3:0] a, input logic [11:0] d);
    pl_vld  = 1'b1;
    pl_all  = all;
    pl_addr = a;
    pl_dat  = d;
    @(negedge clk);
    pl_vld  = 1'b0;
    pl_all  = 1'b0;
  endtask

  logic [7:0] rd_dat;
  logic       rd_err;
  logic       rd_corr;

  task automatic host_read(input logic [3:0] a, input string tag);
    bus.host_req = 1'b1;
    bus.host_we  = 1'b0;
    bus.host_addr = a;
    @(negedge clk);
    bus.host_req = 1'b0;
    check({tag, "_rv_early"}, 32'(bus.host_rvalid), 32'd0);
    @(negedge clk);
    check({tag, "_rv"}, 32'(bus.host_rvalid), 32'd1);
    rd_dat  = bus.host_rdata;
    rd_err  = bus.host_err;
    rd_corr = bus.host_corr;
    @(negedge clk);
  endtask

  task automatic wait_err(input logic [7:0] target, input int lim, output int cyc);
    cyc = 0;
    while (err_cnt != target && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int rv;
  int wr0;

  initial begin
    n_chk = 0; n_bad = 0; wr_total = 0;
    last_wa = '0; last_wd = '0;
    pl_vld = 1'b0; pl_all = 1'b0; pl_addr = '0; pl_dat = '0;
    rst = 1'b1; scrub_en = 1'b0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    // Reset values
    @(negedge clk);
    preload(1'b1, 4'd0, 12'h000);
    check("rst_wr_en",  32'(bus.mem_wr_en),   32'd0);
    check("rst_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_ready",  32'(bus.host_ready),  32'd0);
    check("rst_raddr",  32'(bus.mem_raddr),   32'd0);
    check("rst_wdata",  32'(bus.mem_wdata),   32'd0);
    check("rst_errcnt", 32'(err_cnt),         32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(bus.host_ready), 32'd1);

    // Write addr 3 = 0xA5 -> codeword 0xA5B
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd3; bus.host_wdata = 8'hA5;
    @(negedge clk);
    bus.host_req = 1'b0;
    check("wr_en",    32'(bus.mem_wr_en),  32'd1);
    check("wr_addr",  32'(bus.mem_waddr),  32'd3);
    check("wr_data",  32'(bus.mem_wdata),  32'hA5B);
    check("wr_ready", 32'(bus.host_ready), 32'd0);
    @(negedge clk);
    check("wr_pulse", 32'(bus.mem_wr_en), 32'd0);

    // Clean read back
    host_read(4'd3, "rd3");
    check("rd3_data", 32'(rd_dat),  32'hA5);
    check("rd3_err",  32'(rd_err),  32'd0);
    check("rd3_corr", 32'(rd_corr), 32'd0);

    // Single data-bit error on the all-zero codeword: syndrome 0x3
    preload(1'b0, 4'd5, 12'h010);
    host_read(4'd5, "rd5");
    check("rd5_data",   32'(rd_dat),  CORR ? 32'h00 : 32'h01);
    check("rd5_err",    32'(rd_err),  32'd1);
    check("rd5_corr",   32'(rd_corr), CORR ? 32'd1 : 32'd0);
    check("rd5_errcnt", 32'(err_cnt), 32'd1);
    check("rd5_corrcnt", 32'(corr_cnt), 32'd0);
    check("rd5_no_wb",  32'(mem[5]),  32'h010);

    // Scrub of corrupted addr 0, then a full walk back to it
    preload(1'b0, 4'd5, 12'h000);
    preload(1'b0, 4'd0, 12'h010);
    wr0 = wr_total;
    scrub_en = 1'b1;
    wait_err(8'd2, 40, cyc);
    check("scr_first_lat", 32'(cyc), 32'd6);
    check("scr_errcnt",    32'(err_cnt), 32'd2);
    check("scr_raddr",     32'(bus.mem_raddr), 32'd0);
    cyc = 0;
    repeat (2) begin @(negedge clk); cyc++; end
    check("scr_wb_count", 32'(wr_total - wr0), CORR ? 32'd1 : 32'd0);
    if (CORR) begin
      check("scr_wb_addr", 32'(last_wa), 32'd0);
      check("scr_wb_data", 32'(last_wd), 32'h000);
    end
    check("scr_mem0", 32'(mem[0]), CORR ? 32'h000 : 32'h010);
    preload(1'b0, 4'd0, 12'h010);
    cyc++;
    while (err_cnt != 8'd3 && cyc < 200) begin @(negedge clk); cyc++; end
    scrub_en = 1'b0;
    check("scr_wrap_period", 32'(cyc), 32'd64);
    check("scr_wrap_raddr",  32'(bus.mem_raddr), 32'd0);

    // Host strict priority; a second expiry does not queue an extra scrub
    preload(1'b0, 4'd0, 12'h000);
    preload(1'b0, 4'd1, 12'h010);
    preload(1'b0, 4'd2, 12'h010);
    check("scr_corrcnt", 32'(corr_cnt), CORR ? 32'd2 : 32'd0);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'd3;
    scrub_en = 1'b1;
    rv = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.host_rvalid) rv++;
    end
    bus.host_req = 1'b0;
    scrub_en = 1'b0;
    check("prio_rvalids", 32'(rv), 32'd12);
    check("prio_errcnt",  32'(err_cnt), 32'd3);
    check("prio_raddr",   32'(bus.mem_raddr), 32'd3);
    repeat (20) @(negedge clk);
    check("prio_one_scrub", 32'(err_cnt), 32'd4);
    check("prio_raddr2",    32'(bus.mem_raddr), 32'd1);
    check("prio_corrcnt",   32'(corr_cnt), CORR ? 32'd3 : 32'd0);

    // 300 uncorrectable scrub errors (syndrome 0x9) saturate err_cnt
    preload(1'b1, 4'd0, 12'h009);
    scrub_en = 1'b1;
    repeat (1250) @(negedge clk);
    scrub_en = 1'b0;
    repeat (8) @(negedge clk);
    check("sat_errcnt",  32'(err_cnt),  32'd255);
    check("sat_corrcnt", 32'(corr_cnt), CORR ? 32'd3 : 32'd0);

    // Reset in the WRITE cycle drops the strobe and loses the write
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 4'd7; bus.host_wdata = 8'h3C;
    @(negedge clk);
    bus.host_req = 1'b0;
    check("rstw_wr_en", 32'(bus.mem_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_drop",    32'(bus.mem_wr_en), 32'd0);
    check("rstw_errcnt",  32'(err_cnt),  32'd0);
    check("rstw_corrcnt", 32'(corr_cnt), 32'd0);
    check("rstw_ready",   32'(bus.host_ready), 32'd0);
    check("rstw_waddr",   32'(bus.mem_waddr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready_rel", 32'(bus.host_ready), 32'd1);
    check("rstw_lost",      32'(mem[7]), 32'h009);

    // Timer and scrub pointer restart from zero after reset
    preload(1'b1, 4'd0, 12'h000);
    preload(1'b0, 4'd0, 12'h009);
    scrub_en = 1'b1;
    wait_err(8'd1, 40, cyc);
    scrub_en = 1'b0;
    check("post_rst_lat",   32'(cyc), 32'd6);
    check("post_rst_raddr", 32'(bus.mem_raddr), 32'd0);
    check("post_rst_err",   32'(err_cnt), 32'd1);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
